mux_arb_reg: RTL
================

Name: mux_arb_reg

Overview:
- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake.
- Successor to the 8-to-1 single-bit gate-level mux.
- Selection comes from an external select bus (MODE 0) or an internal round-robin arbiter (MODE 1).
- One output register stage; sits between multiple datapath producers (ALU/shift/load results) and a single consumer.

Parameters:
- N_CH, 8, number of input channels (2..16).
- W, 32, data width per channel.
- MODE, 0, 0 = external select, 1 = round-robin arbitration.
- SEL_W (localparam), $clog2(N_CH), select/channel-index width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N_CH*W  channel i occupies bits [i*W +: W].
- in_valid  input  N_CH  per-channel data valid.
- in_ready  output  N_CH  per-channel accept; combinational.
- sel  input  SEL_W  channel select; used only when MODE=0, ignored otherwise.
- out_data  output  W  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer accept.
- out_ch  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- One clock, clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - out_valid=0, out_data=0, out_ch=0.
  - RR pointer = N_CH-1, so channel 0 has first priority.
  - Lock state cleared (when enabled).
- load = !out_valid || out_ready.
  - Output register accepts new data only when load=1.
  - Full throughput, 1-cycle latency: an input beat accepted in cycle t appears on out_data in cycle t+1.
- MODE 0:
  - grant = one-hot(sel).
  - If sel >= N_CH: no grant, all in_ready=0, no transfer.
- MODE 1:
  - grant = first valid channel searching upward from pointer+1, wrapping N_CH-1 -> 0.
  - No valid channel: grant=0.
- in_ready[i] = grant[i] && load.
  - in_ready never depends on in_valid of the granted channel itself (MODE 0); in MODE 1 it depends only on in_valid of the channel vector.
- Transfer on channel g when in_valid[g] && in_ready[g]:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - MODE 1: pointer <= g. Pointer updates only on transfer.
- No transfer and out_ready=1: out_valid <= 0; out_data and out_ch hold their last value.
- Stall (out_valid && !out_ready): out_data, out_ch, out_valid hold; all in_ready=0.
- Simultaneous drain and fill in the same cycle: out_valid stays 1 and the new beat is loaded (no bubble).
- Reset mid-operation: the in-flight output beat is dropped, pointer returns to N_CH-1, and in_ready=0 during the reset cycle.
- No X propagation: unused in_data bits never reach out_data.

Optional Feature:
- Macro MUX_ARB_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (input, N_CH) and out_last (output, 1, reset 0, registered alongside out_data).
  - Once a channel transfers a beat with in_last=0, the grant locks to that channel (MODE 1 only; MODE 0 ignores the lock) until a beat with in_last=1 transfers.
  - Pointer updates on the last beat only.
  - Reset clears the lock.
- Not defined: ports absent; arbitration is per beat.

Decomposition:
- Package mux_arb_pkg:
  - MODE_SEL=0 and MODE_RR=1 constants.
  - Function onehot_to_idx.
  - Max-channel constant 16.
- Sub-module rr_arbiter (N_CH parameter): inputs req, pointer, lock, lock_ch; output one-hot grant plus index. Instantiated only when MODE=1 (generate).

Test Plan:
- Reset then MODE0 N_CH=8 W=32, sel=3, in_valid=8'h08, in_data[3]=32'hDEADBEEF, out_ready=1 -> in_ready=8'h08; next cycle out_data=DEADBEEF, out_valid=1, out_ch=3.
- MODE0 N_CH=6, sel=7, all in_valid=1 -> in_ready=0 every cycle; out_valid falls to 0 after the pending beat drains.
- MODE1, all 8 channels valid every cycle, out_ready=1 -> out_ch sequence 0,1,2,…,7,0 on consecutive cycles; one beat per cycle.
- MODE1, only channels 2 and 5 valid, out_ready held 0 for 3 cycles after first load -> out_data/out_ch stable at channel 2, in_ready=0 throughout; on release the next transfer is channel 5, not 2.
- Assert reset during a stalled beat (out_valid=1, out_ready=0) -> next cycle out_valid=0, out_data=0; first grant afterwards is the lowest valid channel.
- MUX_ARB_PKT_LOCK_EN, MODE1: ch1 sends 3 beats (last on 3rd) while ch0 and ch2 are valid -> out_ch=1,1,1 then 2; out_last=1 only on the 3rd beat.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the mux_arb_reg registered multiplexer/arbiter.
package mux_arb_pkg;

  typedef enum int unsigned {
    MODE_SEL = 0,
    MODE_RR  = 1
  } mode_e;

  localparam int unsigned MAX_CH = 16;
  localparam int unsigned IDX_W  = $clog2(MAX_CH);

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_arb_reg_rr_arbiter.sv
// Round-robin grant search starting just above the pointer; a held lock pins the grant.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int unsigned N_CH  = 8,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] pointer,
  input  logic             lock,
  input  logic [SEL_W-1:0] lock_ch,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic              found;
  logic [MAX_CH-1:0] grant_ext;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (lock) begin
      grant[lock_ch] = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= N_CH; k++) begin
        if (!found && req[(32'(pointer) + k) % N_CH]) begin
          grant[(32'(pointer) + k) % N_CH] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_ext = '0;
    grant_ext[N_CH-1:0] = grant;
  end

  assign grant_idx = SEL_W'(onehot_to_idx(grant_ext));

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel registered mux with valid/ready handshake; external select or round-robin.
// Optional packet lock (in_last/out_last) enabled by defining MUX_ARB_PKT_LOCK_EN.
module mux_arb_reg
  import mux_arb_pkg::*;
#(
  parameter  int unsigned N_CH  = 8,
  parameter  int unsigned W     = 32,
  parameter  int unsigned MODE  = 0,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [SEL_W-1:0]  sel,
`ifdef MUX_ARB_PKT_LOCK_EN
  input  logic [N_CH-1:0]   in_last,
  output logic              out_last,
`endif
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_ch
);

  logic             load;
  logic             xfer;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] gidx;
  logic [W-1:0]     gdata;

  assign load     = !out_valid || out_ready;
  assign in_ready = reset ? '0 : (grant & {N_CH{load}});
  assign xfer     = |(in_valid & in_ready);

  // One-hot AND-OR select keeps unselected channel bits off out_data.
  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) gdata = in_data[i*W +: W];
    end
  end

`ifdef MUX_ARB_PKT_LOCK_EN
  logic glast;

  always_comb begin
    glast = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) glast = in_last[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     out_last <= 1'b0;
    else if (xfer) out_last <= glast;
  end
`endif

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] ptr;
      logic             lock;
      logic [SEL_W-1:0] lock_ch;
      logic             unused_sel;

      assign unused_sel = ^sel;

      rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req      (in_valid),
        .pointer  (ptr),
        .lock     (lock),
        .lock_ch  (lock_ch),
        .grant    (grant),
        .grant_idx(gidx)
      );

`ifdef MUX_ARB_PKT_LOCK_EN
      // Pointer advances only at packet end so the next packet starts after this channel.
      always_ff @(posedge clk) begin
        if (reset) begin
          ptr     <= SEL_W'(N_CH - 1);
          lock    <= 1'b0;
          lock_ch <= '0;
        end else if (xfer) begin
          lock    <= !glast;
          lock_ch <= gidx;
          if (glast) ptr <= gidx;
        end
      end
`else
      assign lock    = 1'b0;
      assign lock_ch = '0;

      always_ff @(posedge clk) begin
        if (reset)     ptr <= SEL_W'(N_CH - 1);
        else if (xfer) ptr <= gidx;
      end
`endif
    end else begin : g_sel
      always_comb begin
        grant = '0;
        if (32'(sel) < N_CH) grant[sel] = 1'b1;
      end

      assign gidx = sel;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gdata;
      out_ch    <= gidx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
